seq_shift_add_mul: RTL and testbench

//   Iterative shift-add unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH product, one partial product per clock.

---
 rtl/mul_pkg.sv | 8 +
 rtl/mul_step.sv | 12 +
 rtl/seq_shift_add_mul.sv | 76 +++++++
 tb/tb_seq_shift_add_mul.sv | 118 +++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding, default width and count-width helper for seq_shift_add_mul
package mul_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
  localparam int MUL_WIDTH_DEFAULT = 8;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/mul_step.sv
// mul_step: one shift-add iteration; ports acc (2W partial product/multiplier), mcand (W), nxt (next acc)
module mul_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] nxt
);
  logic [WIDTH:0] sum;
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mcand : {WIDTH{1'b0}}};
  assign nxt = {sum, acc[WIDTH-1:1]};
endmodule

// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul: iterative WIDTHxWIDTH shift-add multiplier with valid/ready in and out
// Ports: clk, rst (async high), in_valid/in_ready/a/b operand handshake, out_valid/out_ready/product
// result handshake, busy (BUSY or DONE). Macro SIGNED_MUL_EN adds op_signed (two's complement operands).
module seq_shift_add_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SIGNED_MUL_EN
  input  logic               op_signed,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  mul_state_t state;
  logic [WIDTH-1:0] mcand, ma, mb;
  logic [2*WIDTH-1:0] acc, nxt;
  logic [CW-1:0] count;
  logic sign, sg;
`ifdef SIGNED_MUL_EN
  logic sa, sb;
  assign sa = op_signed & a[WIDTH-1];
  assign sb = op_signed & b[WIDTH-1];
  assign sg = sa ^ sb;
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
`else
  assign sg = 1'b0;
  assign ma = a;
  assign mb = b;
`endif
  mul_step #(.WIDTH(WIDTH)) u_step (.acc(acc), .mcand(mcand), .nxt(nxt));
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      count   <= '0;
      sign    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= BUSY;
          mcand <= ma;
          acc   <= {{WIDTH{1'b0}}, mb};
          count <= '0;
          sign  <= sg;
        end
        BUSY: begin
          acc   <= nxt;
          count <= count + 1'b1;
          if (count == LAST) begin
            state   <= DONE;
            product <= sign ? -nxt : nxt;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_shift_add_mul.sv
// tb_seq_shift_add_mul: directed and random checks of seq_shift_add_mul at WIDTH=8 and WIDTH=4
module tb_seq_shift_add_mul;
  logic clk = 0, rst = 1;
  logic v8 = 0, ir8, ov8, or8 = 0, busy8;
  logic [7:0] a8 = 0, b8 = 0;
  logic [15:0] p8;
  logic v4 = 0, ir4, ov4, or4 = 0, busy4;
  logic [3:0] a4 = 0, b4 = 0;
  logic [7:0] p4;
  logic s8 = 0, s4 = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  seq_shift_add_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
`ifdef SIGNED_MUL_EN
    .op_signed(s8),
`endif
    .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
  );
  seq_shift_add_mul #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
`ifdef SIGNED_MUL_EN
    .op_signed(s4),
`endif
    .in_valid(v4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic sg,
                      input logic [15:0] exp, input int hold, input bit poke);
    int lat;
    @(negedge clk);
    chk("idle_rdy", ir8, 1);
    a8 = x; b8 = y; v8 = 1; s8 = sg;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      v8 = poke && lat == 3;
      if (poke && lat == 3) begin a8 = 8'd7; b8 = 8'd7; end
      if (lat < 9) chk("busy_rdy", {busy8, ir8}, 2'b10);
    end while (!ov8 && lat < 40);
    v8 = 0;
    chk("lat", lat, 9);
    chk("prod", p8, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_v", ov8, 1);
      chk("hold_p", p8, exp);
      chk("hold_rdy", ir8, 0);
    end
    or8 = 1;
    @(negedge clk);
    or8 = 0;
    chk("drain", {ov8, ir8, busy8}, 3'b010);
    chk("keep_p", p8, exp);
  endtask
  initial begin
    int lat;
    logic [7:0] x, y;
    #1;
    chk("rst_out8", {ir8, ov8, busy8}, 3'b100);
    chk("rst_p8", p8, 0);
    chk("rst_out4", {ir4, ov4, busy4}, 3'b100);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    a4 = 15; b4 = 15; v4 = 1; or4 = 1;
    lat = 0;
    do begin
      @(negedge clk);
      v4 = 0;
      lat++;
    end while (!ov4 && lat < 40);
    chk("w4_lat", lat, 5);
    chk("w4_prod", p4, 225);
    @(negedge clk);
    chk("w4_rdy", {ir4, ov4}, 2'b10);
    or4 = 0;
    run8(8'd0, 8'd200, 0, 16'd0, 0, 0);
    run8(8'd255, 8'd1, 0, 16'd255, 0, 0);
    run8(8'd255, 8'd255, 0, 16'd65025, 1, 0);
    run8(8'd13, 8'd11, 0, 16'd143, 5, 0);
    run8(8'd3, 8'd4, 0, 16'd12, 0, 1);
    @(negedge clk);
    a8 = 9; b8 = 9; v8 = 1;
    @(negedge clk);
    v8 = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    chk("abort_out", {ir8, ov8, busy8}, 3'b100);
    chk("abort_p", p8, 0);
    @(negedge clk);
    rst = 0;
    run8(8'd6, 8'd7, 0, 16'd42, 0, 0);
`ifdef SIGNED_MUL_EN
    run8(8'h80, 8'h80, 1, 16'd16384, 0, 0);
    run8(8'h80, 8'h7F, 1, 16'hC080, 0, 0);
    run8(8'hFF, 8'd5, 1, 16'hFFFB, 2, 0);
    run8(8'hFF, 8'd5, 0, 16'd1275, 0, 0);
`endif
    for (int n = 0; n < 1000; n++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      run8(x, y, 0, 16'(x) * 16'(y), $urandom_range(0, 3), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
